// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared codes and types for the pipeline hazard controller
package hazard_pkg;

    localparam int DEFAULT_REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_LUI = 2'b11;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazardState_t;

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one tracking stage with hold and bubble controls
module hazard_stage_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall, flush, freeze and forwarding control for the 5-stage pipeline
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdD,
    input  logic                  regWriteD,
    input  logic                  memReadD,
    input  logic                  memWriteD,
    input  logic                  luiD,
    input  logic                  branchTakenE,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  freeze,
    output logic [1:0]            fwdAE,
    output logic [1:0]            fwdBE
);

    localparam int EW    = 3 * REG_ADDR_W + 4;
    localparam int MW    = REG_ADDR_W + 3;
    localparam int WW    = REG_ADDR_W + 1;
    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    logic [REG_ADDR_W-1:0] rs1E, rs2E, rdE, rdM, rdW;
    logic                  regWriteE, memReadE, memAccessE, luiE;
    logic                  regWriteM, memAccessM, luiM;
    logic                  regWriteW;
    logic [EW-1:0]         eQ;
    logic [MW-1:0]         mQ;
    logic [WW-1:0]         wQ;

    hazardState_t          state;
    logic [CNT_W-1:0]      cnt;
    logic                  run, loadUse;
    logic                  memHitA, memHitB, wbHitA, wbHitB;

    hazard_stage_reg #(.WIDTH(EW)) stageE (
        .clk    (clk),
        .reset  (reset),
        .hold   (freeze),
        .bubble (flushE),
        .d      ({rs1D, rs2D, rdD, regWriteD, memReadD, memReadD | memWriteD, luiD}),
        .q      (eQ)
    );

    hazard_stage_reg #(.WIDTH(MW)) stageM (
        .clk    (clk),
        .reset  (reset),
        .hold   (freeze),
        .bubble (1'b0),
        .d      ({rdE, regWriteE, memAccessE, luiE}),
        .q      (mQ)
    );

    hazard_stage_reg #(.WIDTH(WW)) stageW (
        .clk    (clk),
        .reset  (reset),
        .hold   (freeze),
        .bubble (1'b0),
        .d      ({rdM, regWriteM}),
        .q      (wQ)
    );

    assign {rs1E, rs2E, rdE, regWriteE, memReadE, memAccessE, luiE} = eQ;
    assign {rdM, regWriteM, memAccessM, luiM}                       = mQ;
    assign {rdW, regWriteW}                                         = wQ;

    // The wait is always opened by the access now parked in M, so both terms agree.
    assign freeze = (state == MEM_WAIT) && memAccessM;
    assign run    = !freeze;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if ((MEM_LAT > 1) && memAccessE) begin
                        state <= MEM_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign loadUse = memReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    // A taken branch squashes the dependent instruction, so it overrides the stall.
    assign stallF = run && loadUse && !branchTakenE;
    assign stallD = stallF;
    assign flushD = run && branchTakenE;
    assign flushE = run && (branchTakenE || loadUse);

    assign memHitA = regWriteM && (rdM != '0) && (rdM == rs1E);
    assign memHitB = regWriteM && (rdM != '0) && (rdM == rs2E);
    assign wbHitA  = regWriteW && (rdW != '0) && (rdW == rs1E);
    assign wbHitB  = regWriteW && (rdW != '0) && (rdW == rs2E);

    always_comb begin
        fwdAE = FWD_REG;
        if (memHitA) begin
            fwdAE = luiM ? FWD_LUI : FWD_MEM;
        end else if (wbHitA) begin
            fwdAE = FWD_WB;
        end
    end

    always_comb begin
        fwdBE = FWD_REG;
        if (memHitB) begin
            fwdBE = luiM ? FWD_LUI : FWD_MEM;
        end else if (wbHitB) begin
            fwdBE = FWD_WB;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized bench against an instruction-level pipeline model
module tb_hazard_control_unit;

    localparam int LAT [3] = '{3, 1, 4};

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       ma;
        logic       lui;
    } ins_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rdD;
    logic       regWriteD, memReadD, memWriteD, luiD, branchTakenE;
    logic       stallF [3];
    logic       stallD [3];
    logic       flushD [3];
    logic       flushE [3];
    logic       freeze [3];
    logic [1:0] fwdAE [3];
    logic [1:0] fwdBE [3];

    ins_t eS [3];
    ins_t mS [3];
    ins_t wS [3];
    int   frz [3];
    int   assertCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        hazard_control_unit #(.REG_ADDR_W(5), .MEM_LAT(LAT[g])) dut (
            .clk          (clk),
            .reset        (reset),
            .rs1D         (rs1D),
            .rs2D         (rs2D),
            .rdD          (rdD),
            .regWriteD    (regWriteD),
            .memReadD     (memReadD),
            .memWriteD    (memWriteD),
            .luiD         (luiD),
            .branchTakenE (branchTakenE),
            .stallF       (stallF[g]),
            .stallD       (stallD[g]),
            .flushD       (flushD[g]),
            .flushE       (flushE[g]),
            .freeze       (freeze[g]),
            .fwdAE        (fwdAE[g]),
            .fwdBE        (fwdBE[g])
        );
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] refFwd(input int i, input logic [4:0] rs);
        if (mS[i].rw && mS[i].rd != 0 && mS[i].rd == rs) return mS[i].lui ? 2'd3 : 2'd2;
        if (wS[i].rw && wS[i].rd != 0 && wS[i].rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    // {stallF, stallD, flushD, flushE, freeze}
    function automatic logic [4:0] refCtl(input int i);
        bit frozen, brk, lu;
        frozen = frz[i] > 0;
        brk = !frozen && branchTakenE;
        lu = !frozen && eS[i].mr && eS[i].rd != 0 && (eS[i].rd == rs1D || eS[i].rd == rs2D);
        return {lu && !brk, lu && !brk, brk, brk || lu, frozen};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            eS[i] = '0; mS[i] = '0; wS[i] = '0; frz[i] = 0;
        end
    endtask

    task automatic advanceModel();
        logic [4:0] c;
        for (int i = 0; i < 3; i++) begin
            if (frz[i] > 0) begin
                frz[i]--;
            end else begin
                c = refCtl(i);
                if (eS[i].ma && LAT[i] > 1) frz[i] = LAT[i] - 1;
                wS[i] = mS[i];
                mS[i] = eS[i];
                eS[i] = c[1] ? ins_t'('0) :
                        ins_t'{rs1D, rs2D, rdD, regWriteD, memReadD, memReadD | memWriteD, luiD};
            end
        end
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("%s ctl lat%0d", tag, LAT[i]),
                     {stallF[i], stallD[i], flushD[i], flushE[i], freeze[i]}, refCtl(i));
            checkVal($sformatf("%s fwd lat%0d", tag, LAT[i]), {fwdAE[i], fwdBE[i]},
                     {refFwd(i, eS[i].rs1), refFwd(i, eS[i].rs2)});
        end
    endtask

    task automatic setIn(input logic [4:0] r1, r2, rd, input logic rw, mr, mw, lu, br);
        rs1D = r1; rs2D = r2; rdD = rd;
        regWriteD = rw; memReadD = mr; memWriteD = mw; luiD = lu; branchTakenE = br;
    endtask

    task automatic tick(input string tag);
        #1 checkAll(tag);
        @(posedge clk);
        advanceModel();
        @(negedge clk);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        branchTakenE = 1'b0;
        modelReset();
        #1 checkAll(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nFrz [3];
        logic mr, mw, lu;
        reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        @(negedge clk);
        checkAll("reset");
        reset = 1'b0;

        // load x5, then add x6,x5,x1
        setIn(2, 0, 5, 1, 1, 0, 0, 0); tick("lw");
        setIn(5, 1, 6, 1, 0, 0, 0, 0);
        #1 checkVal("lu stallF", stallF[1], 1);
        checkVal("lu flushE", flushE[1], 1);
        tick("lu stall");
        #1 checkVal("lu stall once", stallF[1], 0);
        tick("lu bubble");
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkVal("lu fwd wb", fwdAE[1], 2'b01);
        tick("lu wb");

        // lui x7; addi x8,x7,1 and the x0 variant
        setIn(0, 0, 7, 1, 0, 0, 1, 0); tick("lui");
        setIn(7, 0, 8, 1, 0, 0, 0, 0); tick("addi");
        #1 checkVal("lui fwd", fwdAE[1], 2'b11);
        checkVal("lui no stall", stallF[1], 0);
        setIn(0, 0, 0, 1, 0, 0, 1, 0); tick("lui x0");
        setIn(0, 0, 8, 1, 0, 0, 0, 0); tick("addi x0");
        #1 checkVal("lui x0 fwd", fwdAE[1], 2'b00);

        // both M and W write x9
        setIn(1, 2, 9, 1, 0, 0, 0, 0); tick("w x9 a");
        setIn(3, 4, 9, 1, 0, 0, 0, 0); tick("w x9 b");
        setIn(0, 9, 10, 1, 0, 0, 0, 0); tick("r x9");
        #1 checkVal("mem prio fwdB", fwdBE[1], 2'b10);

        // taken branch coinciding with a load-use pair
        setIn(1, 0, 3, 1, 1, 0, 0, 0); tick("lw x3");
        setIn(3, 0, 4, 1, 0, 0, 0, 1);
        #1 checkVal("br flushD", flushD[1], 1);
        checkVal("br flushE", flushE[1], 1);
        checkVal("br no stall", stallF[1], 0);
        tick("br+lu");
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) tick("drain");

        // sw then lw back to back; branch pulse during the freeze
        setIn(1, 2, 0, 0, 0, 1, 0, 0); tick("sw");
        setIn(1, 0, 4, 1, 1, 0, 0, 0); tick("lw b2b");
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        nFrz = '{0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            branchTakenE = (k == 0);
            #1;
            for (int i = 0; i < 3; i++) if (freeze[i]) nFrz[i]++;
            tick("b2b");
        end
        for (int i = 0; i < 3; i++)
            checkVal($sformatf("freeze cycles lat%0d", LAT[i]), nFrz[i], 2 * (LAT[i] - 1));

        // async reset in the middle of a MEM_LAT=4 wait
        setIn(1, 0, 1, 1, 1, 0, 0, 0); tick("lw wait");
        setIn(0, 0, 0, 0, 0, 0, 0, 0); tick("enter wait");
        #1 checkVal("wait freeze", freeze[2], 1);
        #1 reset = 1'b1;
        modelReset();
        #1 checkVal("async reset freeze", freeze[2], 0);
        checkAll("async reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick("after reset");

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(299) == 0) doReset("rand reset");
            lu = ($urandom_range(99) < 15);
            mr = !lu && ($urandom_range(99) < 25);
            mw = !lu && !mr && ($urandom_range(99) < 12);
            setIn(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                  $urandom_range(99) < 60, mr, mw, lu, $urandom_range(99) < 10);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
